// File: rtl/iom_bus_master.sv
// iom_bus_master: single-outstanding initiator for the MCS IO bus.
// A valid/ready command becomes one strobed IO bus transaction. The master
// then waits for io_ready, or gives up after TIMEOUT_CYCLES, and returns a
// response on a valid/ready channel.
//
// Handshake rule for both channels: a transfer happens on the rising edge
// where valid and ready are both high. Valid is held, with its payload stable,
// until that edge. The command side is only ready in IDLE, so at most one
// transaction is ever outstanding.
module iom_bus_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_BITS        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [11:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        io_addr_strobe,
  output logic        io_read_strobe,
  output logic        io_write_strobe,
  output logic [11:0] io_address,
  output logic [3:0]  io_byte_enable,
  output logic [31:0] io_write_data,
  input  logic [31:0] io_read_data,
  input  logic        io_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // The counter is 0 in the first WAIT cycle. The timeout fires in the WAIT
  // cycle whose incremented count reaches TIMEOUT_CYCLES-1, so that the
  // response appears TIMEOUT_CYCLES cycles after the strobe.
  localparam logic [TO_BITS:0] TO_LIMIT =
    (TO_BITS+1)'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit TO_ENABLED = (TIMEOUT_CYCLES != 0);

  state_t             state;
  state_t             state_next;
  logic [TO_BITS-1:0] cnt;
  logic [TO_BITS:0]   cnt_inc;
  logic               timeout_hit;
  logic               is_write;
  logic               accept;

  assign accept = (state == IDLE) && cmd_valid;

  // Timeout detection from the incremented wait counter.
  always_comb begin
    cnt_inc     = {1'b0, cnt} + (TO_BITS+1)'(1);
    timeout_hit = TO_ENABLED && (cnt_inc >= TO_LIMIT);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and the handshake outputs decoded from the state.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = STROBE;
      end
      STROBE: state_next = WAIT;
      WAIT: begin
        // io_ready takes priority over a timeout in the same cycle.
        if (io_ready || timeout_hit) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus fields, registered strobes, the wait counter and the response payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_addr_strobe  <= 1'b0;
      io_read_strobe  <= 1'b0;
      io_write_strobe <= 1'b0;
      io_address      <= '0;
      io_byte_enable  <= '0;
      io_write_data   <= '0;
      is_write        <= 1'b0;
      cnt             <= '0;
      rsp_rdata       <= '0;
      rsp_timeout     <= 1'b0;
    end else begin
      // The strobes are set on the accept edge, so they are high only in STROBE.
      io_addr_strobe  <= accept;
      io_read_strobe  <= accept && !cmd_write;
      io_write_strobe <= accept && cmd_write;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            io_address     <= cmd_addr;
            io_byte_enable <= cmd_be;
            io_write_data  <= cmd_write ? cmd_wdata : '0;
            is_write       <= cmd_write;
          end
        end
        STROBE: cnt <= '0;
        WAIT: begin
          if (io_ready) begin
            rsp_rdata   <= is_write ? '0 : io_read_data;
            rsp_timeout <= 1'b0;
          end else if (timeout_hit) begin
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
          end else begin
            cnt <= cnt + TO_BITS'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            io_address     <= '0;
            io_byte_enable <= '0;
            io_write_data  <= '0;
            rsp_rdata      <= '0;
            rsp_timeout    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iom_bus_master.sv
// tb_iom_bus_master: directed transactions on iom_bus_master with a short
// timeout. Expected bus strobes and responses go into queues; monitors on the
// falling edge pop the queues and compare.
module tb_iom_bus_master;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        io_addr_strobe;
  logic        io_read_strobe;
  logic        io_write_strobe;
  logic [11:0] io_address;
  logic [3:0]  io_byte_enable;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        io_ready;

  iom_bus_master #(.TIMEOUT_CYCLES(TO), .TO_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
    .io_write_strobe(io_write_strobe), .io_address(io_address),
    .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
    .io_read_data(io_read_data), .io_ready(io_ready)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;

  // Each scoreboard entry is {timeout, rdata}.
  logic [32:0] exp_q[$];
  // Each bus entry is {read_strobe, write_strobe, addr, be, wdata}.
  logic [49:0] bus_q[$];
  logic        strobe_prev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: pops and compares once per response handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got %h with no expected response", {rsp_timeout, rsp_rdata});
      end else begin
        check("rsp", 64'({rsp_timeout, rsp_rdata}), 64'(exp_q.pop_front()));
      end
    end
  end

  // Bus monitor: each strobe is one cycle wide and matches the issued command.
  always @(negedge clk) begin
    if (io_addr_strobe) begin
      check("strobe_width", 64'(strobe_prev), 64'(0));
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_unexpected: got strobe at addr %h with no command issued", io_address);
      end else begin
        check("bus_fields",
              64'({io_read_strobe, io_write_strobe, io_address, io_byte_enable, io_write_data}),
              64'(bus_q.pop_front()));
      end
    end else if (io_read_strobe || io_write_strobe) begin
      checks++;
      errors++;
      $display("FAIL orphan_strobe: got rd=%b wr=%b without addr strobe", io_read_strobe, io_write_strobe);
    end
    strobe_prev <= io_addr_strobe;
  end

  // Driver: issue one command, act as responder, then apply response backpressure.
  // ready_after < 0 means the responder never answers.
  task automatic run_txn(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int ready_after, input logic [31:0] rdata,
                         input int exp_lat, input int hold, input bit late_pulse);
    logic        exp_to;
    logic [31:0] exp_rd;
    int          w;
    int          k;
    int          lat;
    exp_to = (ready_after < 0);
    exp_rd = (wr || exp_to) ? 32'h0 : rdata;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_be    = be;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("accept_wait", 64'(w), 64'(0));
    bus_q.push_back({!wr, wr, addr, be, wr ? wdata : 32'h0});
    exp_q.push_back({exp_to, exp_rd});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_wdata = $urandom;
    k = 1;
    lat = 0;
    while (k < 40) begin
      if (rsp_valid) begin
        lat = k;
        break;
      end
      io_ready     = (ready_after >= 0) && (k == 1 + ready_after);
      io_read_data = io_ready ? rdata : $urandom;
      @(posedge clk); #1;
      k++;
    end
    io_ready = 1'b0;
    check("latency", 64'(lat), 64'(exp_lat));
    for (int h = 0; h < hold; h++) begin
      cmd_valid    = 1'b1;
      cmd_write    = ~wr;
      cmd_addr     = 12'hFFF;
      io_ready     = late_pulse && (h == 2);
      io_read_data = 32'h5A5A_5A5A;
      check("hold_handshake", 64'({rsp_valid, cmd_ready}), 64'(2'b10));
      check("hold_data", 64'({rsp_timeout, rsp_rdata}), 64'({exp_to, exp_rd}));
      check("hold_addr", 64'(io_address), 64'(addr));
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    io_ready  = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_idle", 64'({rsp_valid, cmd_ready, io_address, io_write_data}),
          64'({1'b0, 1'b1, 12'h0, 32'h0}));
  endtask

  // Driver: issue a read and assert reset in the middle of cycle reset_k after accept.
  task automatic abort_txn(input int reset_k, input int ready_k);
    int k;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 12'h0AB;
    cmd_be    = 4'hF;
    check("abort_accept", 64'(cmd_ready), 64'(1));
    bus_q.push_back({1'b1, 1'b0, 12'h0AB, 4'hF, 32'h0});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    k = 1;
    while (k < reset_k) begin
      io_ready     = (k == ready_k);
      io_read_data = 32'h7777_7777;
      @(posedge clk); #1;
      k++;
    end
    io_ready = 1'b0;
    check("pre_reset_valid", 64'(rsp_valid), 64'(ready_k >= 0));
    #2 rst_n = 1'b0;
    #1;
    check("reset_abort",
          64'({io_addr_strobe, io_read_strobe, io_write_strobe, rsp_valid, io_address, io_byte_enable}),
          64'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_idle", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
  endtask

  // Directed test sequence.
  initial begin
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_write    = 1'b0;
    cmd_addr     = '0;
    cmd_wdata    = '0;
    cmd_be       = '0;
    rsp_ready    = 1'b0;
    io_read_data = '0;
    io_ready     = 1'b0;
    strobe_prev  = 1'b0;
    #12;
    check("reset_outputs",
          64'({rsp_valid, io_addr_strobe, io_read_strobe, io_write_strobe, rsp_timeout,
               io_address, io_byte_enable}), 64'(0));
    check("reset_data", 64'({rsp_rdata, io_write_data}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_cmd_ready", 64'(cmd_ready), 64'(1));

    // Read with the quickest responder, then a write with partial byte enables.
    run_txn(1'b0, 12'h000, 32'h0, 4'hF, 1, 32'hDEAD_BEEF, 3, 0, 1'b0);
    run_txn(1'b1, 12'h004, 32'h1234_5678, 4'b0011, 1, 32'hAAAA_5555, 3, 0, 1'b0);
    // Timeout with a late io_ready pulse while the response waits.
    run_txn(1'b0, 12'h010, 32'h0, 4'hF, -1, 32'h1111_1111, TO + 1, 4, 1'b1);
    // A spurious io_ready in IDLE must not start anything.
    io_ready = 1'b1;
    @(posedge clk); #1;
    io_ready = 1'b0;
    check("spurious_ready_idle", 64'({cmd_ready, rsp_valid, io_addr_strobe}), 64'(3'b100));
    // io_ready arrives in the same cycle as the timeout.
    run_txn(1'b0, 12'h020, 32'h0, 4'hF, TO - 1, 32'hCAFE_F00D, TO + 1, 0, 1'b0);
    // Response held off for 10 cycles.
    run_txn(1'b0, 12'h123, 32'h0, 4'hF, 2, 32'h0F0F_1234, 4, 10, 1'b0);
    // Write that times out.
    run_txn(1'b1, 12'hFFC, 32'hA5A5_A5A5, 4'b1100, -1, 32'h0, TO + 1, 0, 1'b0);
    // Reset while waiting for io_ready, and reset while the response is pending.
    abort_txn(3, -1);
    abort_txn(3, 2);
    // A new read completes normally after the resets.
    run_txn(1'b0, 12'h0AB, 32'h0, 4'hF, 1, 32'h1357_9BDF, 3, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    check("bus_q_empty", 64'(bus_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
